uart_prog_tx: RTL
=================

// Module: uart_prog_tx
// PURPOSE
//  Host-side UART transmitter that streams 32-bit program words into the CPU's
//  UART loader (cpu_uart_top rx path). Each accepted word is serialised as four
//  8N1 bytes, least-significant byte first, least-significant bit first.
//  Used in benches and the FPGA programming path to feed the instruction image.
//  A valid/ready handshake paces words. A counter reports how many words have completed.
// PARAMETERS
//  CLKS_PER_BIT  default 4   clk cycles per UART bit (>=2)
//  STOP_BITS     default 1   stop-bit count per byte (1 or 2)
//  CNT_W         default 16  width of words_sent counter
// PORTS
//  clk         in   1      system clock, rising edge
//  rst         in   1      asynchronous reset, active-high
//  word_data   in   32     word to transmit, sampled on accept
//  word_valid  in   1      word_data is presented
//  word_ready  out  1      block can accept a word this cycle
//  tx          out  1      UART serial line, idle high
//  busy        out  1      a word is being serialised
//  words_sent  out  CNT_W  count of fully transmitted words
// BEHAVIOUR
//  Reset values (async, immediate): tx=1, word_ready=1, busy=0, words_sent=0,
//   state=IDLE. All internal counters are cleared.
//  Accept: word_valid & word_ready at a rising edge. word_data is latched into a
//   32-bit shift register. byte_idx=0. State goes to START. word_ready=0 and
//   busy=1 from the next cycle.
//  word_ready=1 only in IDLE. word_data changes while not ready are ignored.
//  FSM states are IDLE, START, DATA, STOP. Each bit is held for exactly
//   CLKS_PER_BIT cycles by a baud counter that reloads at every bit boundary.
//   START: tx=0 for 1 bit -> DATA.
//   DATA: tx=shreg[0]; after each bit, shift right by 1. After 8 bits -> STOP.
//   STOP: tx=1 for STOP_BITS bits. Then:
//    - byte_idx<3: byte_idx+1 -> START (no idle gap between bytes).
//    - byte_idx==3: words_sent+1 (wraps modulo 2^CNT_W) -> IDLE.
//  tx is registered: the start bit appears on the cycle after accept.
//  Word duration is 4*(9+STOP_BITS)*CLKS_PER_BIT cycles. In IDLE, word_ready=1
//   and tx=1.
//  Back-to-back: if word_valid is held high, start bits of consecutive words
//   are 4*(9+STOP_BITS)*CLKS_PER_BIT+1 cycles apart (one IDLE cycle).
//  words_sent increments on the same edge that enters IDLE. busy falls on that edge.
//  Reset mid-frame: the frame is abandoned; tx returns high at once.
//   words_sent is cleared and no partial byte resumes after reset.
//  word_valid low in IDLE: tx stays high indefinitely; there is no timeout.
// TESTING
//  1. CPB=4, send 0xFFFFFFFE -> tx bytes FE,FF,FF,FF. Byte0 bits are
//     0,0,1,1,1,1,1,1,1 + stop 1, each 4 cycles. words_sent=1 after 160 cycles.
//  2. Send 0x12345678 then 0xA5A5A5A5 with valid held high -> byte stream
//     78,56,34,12,A5,A5,A5,A5. Start bits of the two words are 161 cycles apart.
//     words_sent=2.
//  3. Loopback into the CPU's UART rx: stream a 4-word image with an encoded
//     SRA, then run -> the first word lands in cell 0 and rf.write_data==-2.
//  4. Assert rst during bit 3 of byte 1 -> tx=1 that cycle, word_ready=1,
//     busy=0, words_sent=0. No further tx toggles until a new accept.
//  5. CNT_W=2, send 5 words -> words_sent sequence 1,2,3,0,1.
//  6. STOP_BITS=2, send 0x000000FF -> each byte frame is 11*4=44 cycles, with
//     tx high for 8 cycles at the end of each byte.

Source files
------------

// File: rtl/uart_prog_tx.sv
// Host-side 8N1 UART transmitter that streams 32-bit program words LSB byte first.
// Each accepted word leaves as four back-to-back byte frames; words_sent counts finished words.
module uart_prog_tx #(
  parameter int CLKS_PER_BIT = 4,
  parameter int STOP_BITS    = 1,
  parameter int CNT_W        = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [31:0]      word_data,
  input  logic             word_valid,
  output logic             word_ready,
  output logic             tx,
  output logic             busy,
  output logic [CNT_W-1:0] words_sent
);

  localparam int BAUD_W = $clog2(CLKS_PER_BIT);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t            state, state_next;
  logic [BAUD_W-1:0] baud_cnt, baud_next;
  logic [2:0]        bit_cnt, bit_next;
  logic [1:0]        byte_idx, byte_next;
  logic [31:0]       shreg, shreg_next;
  logic [CNT_W-1:0]  sent_cnt, sent_next;
  logic              tx_q, tx_next;
  logic              bit_done;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      baud_cnt <= '0;
      bit_cnt  <= '0;
      byte_idx <= '0;
      shreg    <= '0;
      sent_cnt <= '0;
      tx_q     <= 1'b1;
    end else begin
      state    <= state_next;
      baud_cnt <= baud_next;
      bit_cnt  <= bit_next;
      byte_idx <= byte_next;
      shreg    <= shreg_next;
      sent_cnt <= sent_next;
      tx_q     <= tx_next;
    end
  end

  // The shift register already holds the next byte in its low bits after eight shifts,
  // so a new START needs no reload.
  always_comb begin
    state_next = state;
    baud_next  = baud_cnt;
    bit_next   = bit_cnt;
    byte_next  = byte_idx;
    shreg_next = shreg;
    sent_next  = sent_cnt;
    bit_done   = (baud_cnt == BAUD_W'(CLKS_PER_BIT - 1));

    if (state != IDLE) begin
      baud_next = bit_done ? '0 : baud_cnt + BAUD_W'(1);
    end

    case (state)
      IDLE: begin
        if (word_valid) begin
          shreg_next = word_data;
          byte_next  = 2'd0;
          bit_next   = 3'd0;
          baud_next  = '0;
          state_next = START;
        end
      end
      START: begin
        if (bit_done) begin
          bit_next   = 3'd0;
          state_next = DATA;
        end
      end
      DATA: begin
        if (bit_done) begin
          shreg_next = {1'b0, shreg[31:1]};
          if (bit_cnt == 3'd7) begin
            bit_next   = 3'd0;
            state_next = STOP;
          end else begin
            bit_next = bit_cnt + 3'd1;
          end
        end
      end
      STOP: begin
        if (bit_done) begin
          if (bit_cnt == 3'(STOP_BITS - 1)) begin
            bit_next = 3'd0;
            if (byte_idx != 2'd3) begin
              byte_next  = byte_idx + 2'd1;
              state_next = START;
            end else begin
              sent_next  = sent_cnt + CNT_W'(1);
              state_next = IDLE;
            end
          end else begin
            bit_next = bit_cnt + 3'd1;
          end
        end
      end
      default: state_next = IDLE;
    endcase

    // tx is taken from the next state so the line is registered without extra latency.
    case (state_next)
      START:   tx_next = 1'b0;
      DATA:    tx_next = shreg_next[0];
      default: tx_next = 1'b1;
    endcase
  end

  assign word_ready = (state == IDLE);
  assign busy       = (state != IDLE);
  assign tx         = tx_q;
  assign words_sent = sent_cnt;

endmodule
